// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode constants and conditional-invert sequencer state encoding.
package alu_pkg;
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/word_negate_seq_xor_chunk_add.sv
// xor_chunk_add: one CHUNK-bit slice of (chunk ^ {CHUNK{inv}}) + cin with carry out.
module xor_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, chunk ^ {CHUNK{inv}}} + (CHUNK+1)'(cin);
endmodule

// File: rtl/word_negate_seq.sv
// word_negate_seq: chunk-serial pass/invert/negate/abs of a W-bit operand, LSB chunk first.
// Optional NEG_SAT_EN saturates an overflowing negate/abs to the largest positive value.
module word_negate_seq
  import alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         ovf
);
  localparam int N  = W / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t           state, state_n;
  logic [W-1:0]     x_r, z_n;
  logic [1:0]       mode_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] sum;
  logic             inv, carry, cout, accept, last, neg_x, ovf_n;
  assign accept = start && state != RUN;
  assign last   = cnt == CW'(N - 1);
  assign neg_x  = mode == MODE_NEG || (mode == MODE_ABS && x[W-1]);
  xor_chunk_add #(.CHUNK(CHUNK)) u_add (
    .chunk(x_r[cnt*CHUNK +: CHUNK]),
    .inv  (inv),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // Overflow is judged on the final sign bit, produced by the MSB chunk at the last edge.
  assign ovf_n = (mode_r == MODE_NEG || mode_r == MODE_ABS) && x_r[W-1] && sum[CHUNK-1];
  always_comb begin
    z_n = z;
    z_n[cnt*CHUNK +: CHUNK] = sum;
`ifdef NEG_SAT_EN
    z_n = last && ovf_n ? {1'b0, {(W-1){1'b1}}} : z_n;
`endif
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      x_r    <= '0;
      mode_r <= MODE_PASS;
      inv    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      z      <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      x_r    <= x;
      mode_r <= mode;
      inv    <= neg_x || mode == MODE_INV;
      carry  <= neg_x;
      cnt    <= '0;
      z      <= '0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      z     <= z_n;
      carry <= cout;
      cnt   <= cnt + 1'b1;
      ovf   <= last && ovf_n;
    end
endmodule

// File: tb/tb_word_negate_seq.sv
// tb_word_negate_seq: directed vectors with hand-computed results for word_negate_seq (W=16, CHUNK=4).
module tb_word_negate_seq;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] x = 16'h0000;
  logic        busy, done, ovf;
  logic [15:0] z;
  int vectors = 0;
  int errs = 0;
  word_negate_seq #(.W(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .start(start),
    .mode (mode),
    .x    (x),
    .busy (busy),
    .done (done),
    .z    (z),
    .ovf  (ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [1:0] m, input logic [15:0] xv,
                    input logic [15:0] ez, input logic eo);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    x     = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~m;
    x     = ~xv;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " early done"}, done, 0);
    end
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy end"}, busy, 0);
    chk({tag, " z"}, z, ez);
    chk({tag, " ovf"}, ovf, eo);
  endtask
  initial begin
    int saw_done;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset z", z, 0);
    chk("reset ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;
    op("neg5", 2'b10, 16'h0005, 16'hFFFB, 1'b0);
    @(negedge clk);
    chk("neg5 done pulse", done, 0);
    chk("neg5 z held", z, 16'hFFFB);
    op("abs_neg", 2'b11, 16'hFFF3, 16'h000D, 1'b0);
    op("abs_pos", 2'b11, 16'h0032, 16'h0032, 1'b0);
`ifdef NEG_SAT_EN
    op("neg_min", 2'b10, 16'h8000, 16'h7FFF, 1'b1);
    op("abs_min", 2'b11, 16'h8000, 16'h7FFF, 1'b1);
`else
    op("neg_min", 2'b10, 16'h8000, 16'h8000, 1'b1);
    op("abs_min", 2'b11, 16'h8000, 16'h8000, 1'b1);
`endif
    @(negedge clk);
    chk("min ovf held", ovf, 1);
    op("inv", 2'b01, 16'h0032, 16'hFFCD, 1'b0);
    op("pass", 2'b00, 16'h1234, 16'h1234, 1'b0);
    // start stays high through RUN (ignored) and DONE (accepted back-to-back)
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    x     = 16'h0000;
    @(posedge clk);
    #1;
    x = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b busy", busy, 1);
    end
    @(negedge clk);
    chk("neg0 done", done, 1);
    chk("neg0 z", z, 16'h0000);
    chk("neg0 ovf", ovf, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b restart busy", busy, 1);
    chk("b2b restart done", done, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("b2b second done", done, 1);
    chk("b2b second z", z, 16'hFFFD);
    // a start raised mid-RUN must not disturb the operation in flight
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b10;
    x     = 16'h00FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b00;
    x     = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("ignore busy", busy, 1);
    @(negedge clk);
    chk("ignore busy2", busy, 1);
    @(negedge clk);
    chk("ignore done", done, 1);
    chk("ignore z", z, 16'hFF01);
    chk("ignore ovf", ovf, 0);
    @(negedge clk);
    chk("ignore no rerun", busy, 0);
    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b01;
    x     = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-reset partial z", z, 16'h00FF);
    #2;
    rst_b = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    chk("mid reset z", z, 0);
    chk("mid reset ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    chk("no done after reset", saw_done, 0);
    op("recover", 2'b10, 16'h0001, 16'hFFFF, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/word_negate_seq.md
Name: word_negate_seq

Overview:
- Sequential, parametrised successor to the ALU's combinational conditional-invert word block.
- Computes pass, one's complement, two's-complement negate, or absolute value of a W-bit operand.
- Processes CHUNK bits per cycle, LSB chunk first, with a registered carry between chunks, so long words do not need a full-width carry chain.
- Sits in the ALU operand path ahead of the adder/subtractor. Uses a start/busy/done handshake.

Parameters:
- W, 16: operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle. N = W/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- mode  input  2  00 pass, 01 invert, 10 negate, 11 abs
- x  input  W  operand, sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- z  output  W  result, held until next accepted start
- ovf  output  1  negate/abs of most-negative value; held with z

Behaviour:
- Reset: rst_b low asynchronously clears all state. busy=0, done=0, z=0, ovf=0, state=IDLE, chunk counter=0, carry=0.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - Latch x and mode.
  - inv = (mode==01) | (mode==10) | (mode==11 & x[W-1]).
  - carry = (mode==10) | (mode==11 & x[W-1]).
  - Clear z; counter=0; go to RUN.
- RUN, edges E1..EN: chunk k = (x_chunk_k XOR {CHUNK{inv}}) + carry, written to z chunk k. Carry-out is registered as the next carry; counter increments. After EN go to DONE.
- Cycle after EN (state DONE):
  - done=1 for exactly one cycle; busy=0.
  - z final; ovf = (mode==10 | mode==11) & x[W-1] & z[W-1].
  - Next state is IDLE unless start=1, which begins a new operation (back-to-back allowed).
- busy=1 from the cycle after E0 through the cycle ending at EN.
- Latency: start sampled at E0 gives done=1 visible after EN, i.e. sampled at E(N+1). For the defaults that is E5.
- start while busy: ignored, no effect on state or outputs.
- mode and x: ignored except at the accepting edge.
- z: partial values are visible during RUN; z is valid only from done onward.
- Carry out of the MSB chunk is discarded.
- Wrap arithmetic is modulo 2^W.
- Negate 0 gives 0: the carry ripples through all chunks; ovf=0.
- Reset mid-RUN: abort immediately, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro NEG_SAT_EN.
- When defined: if ovf would be 1, z in the DONE cycle is forced to 0 followed by W-1 ones (max positive), and ovf is still 1.
- When undefined: z holds the wrapped result (1 followed by W-1 zeros) and ovf=1.
- Latency is identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - the 2-bit mode constants MODE_PASS, MODE_INV, MODE_NEG, MODE_ABS;
  - the FSM state encoding.
- One natural sub-module, xor_chunk_add: combinational CHUNK-bit slice with inputs chunk, inv, cin and outputs sum, cout.
- The top level instantiates xor_chunk_add once and muxes the active chunk by counter.

Test Plan (W=16, CHUNK=4):
- mode=10, x=0x0005, start pulse -> busy for 4 cycles, done at E5, z=0xFFFB, ovf=0.
- mode=11, x=0xFFF3 -> z=0x000D, ovf=0. Then mode=11, x=0x0032 -> z=0x0032.
- mode=10, x=0x8000 -> z=0x8000, ovf=1. With NEG_SAT_EN: z=0x7FFF, ovf=1.
- mode=01, x=0x0032 -> z=0xFFCD. Then mode=00, x=0x1234 -> z=0x1234, ovf=0.
- mode=10, x=0x0000 -> z=0x0000, ovf=0 (full carry ripple). Then start held high through DONE -> second operation starts with no idle cycle.
- Run mode=10 x=0x00FF, raise start again at E2 with x=0x0001 -> ignored, z=0xFF01. Next run: drop rst_b at E2 -> busy=0, done=0, z=0 immediately, no done pulse.
